// File: rtl/idc_multi.sv
// idc_multi: streaming check-digit validator for letter-prefixed national IDs (mode 0)
// and Luhn numeric strings (mode 1). One character per cycle, one verdict pulse per frame.
module idc_multi #(
   parameter int unsigned N_DIGITS = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       in_mode,
   input  logic [5:0] in_id,
   output logic       out_valid,
   output logic       out_legal_id,
   output logic       out_err
);

   localparam int unsigned CW = $clog2(N_DIGITS + 2);
   localparam int          ND = int'(N_DIGITS);

   typedef enum logic {StIdle, StAcc} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      sum_q, sum_d;
   logic            err_q, err_d;
   logic            mode_q, mode_d;
   logic            out_valid_q, out_valid_d;
   logic            out_legal_q, out_legal_d;
   logic            out_err_q, out_err_d;

   logic            start;
   logic            cur_mode;
   logic            last;
   logic            char_err;
   logic            acc_err;
   int              code;
   int              pos;
   int              weight;
   int              dbl;
   int              term;
   int              acc_sum;

   // Per-character term, frame bookkeeping and verdict generation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      err_d       = err_q;
      mode_d      = mode_q;
      out_valid_d = 1'b0;
      out_legal_d = 1'b0;
      out_err_d   = 1'b0;
      weight      = 0;
      dbl         = 0;
      term        = 0;
      char_err    = 1'b0;
      last        = 1'b0;

      // A character seen in StIdle always opens a frame, so back-to-back frames need no gap.
      start    = (state_q == StIdle);
      cur_mode = start ? in_mode : mode_q;
      pos      = start ? 0 : int'(cnt_q);
      code     = int'(in_id);

      if (!cur_mode) begin
         last = (pos == ND);
         if (pos == 0) begin
            char_err = (code < 10) || (code > 35);
            if (!char_err) begin
               term = ((code / 10) + 9 * (code % 10)) % 10;
            end
         end else begin
            char_err = (code > 9);
            weight   = (pos == ND) ? 1 : ND - pos;
            term     = (code * weight) % 10;
         end
      end else begin
         last     = (pos == ND - 1);
         char_err = (code > 9);
         if (((ND - 1 - pos) % 2) == 1) begin
            dbl  = 2 * code;
            term = ((dbl > 9) ? dbl - 9 : dbl) % 10;
         end else begin
            term = code % 10;
         end
      end

      acc_sum = ((start ? 0 : int'(sum_q)) + term) % 10;
      acc_err = (!start && err_q) || char_err;

      if (in_valid) begin
         if (last) begin
            state_d     = StIdle;
            cnt_d       = '0;
            sum_d       = '0;
            err_d       = 1'b0;
            out_valid_d = 1'b1;
            out_err_d   = acc_err;
            out_legal_d = (acc_sum == 0) && !acc_err;
         end else begin
            state_d = StAcc;
            cnt_d   = CW'(pos + 1);
            sum_d   = 4'(acc_sum);
            err_d   = acc_err;
            mode_d  = cur_mode;
         end
      end else begin
         // Idle cycle, or a frame abandoned mid-way: drop everything accumulated.
         state_d = StIdle;
         cnt_d   = '0;
         sum_d   = '0;
         err_d   = 1'b0;
      end
   end

   // State and registered outputs, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         sum_q       <= '0;
         err_q       <= 1'b0;
         mode_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_legal_q <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         err_q       <= err_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         out_legal_q <= out_legal_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_legal_id = out_legal_q;
   assign out_err      = out_err_q;

endmodule

// File: tb/tb_idc_multi.sv
// Scoreboard bench for idc_multi (N_DIGITS = 9): directed frames push their hand-computed
// verdict; a negedge monitor pops and compares whenever out_valid is seen.
module tb_idc_multi;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_mode = 1'b0;
   logic [5:0] in_id = '0;
   logic       out_valid;
   logic       out_legal_id;
   logic       out_err;

   typedef struct packed {
      logic legal;
      logic err;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   idc_multi #(.N_DIGITS(9)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_mode      (in_mode),
      .in_id        (in_id),
      .out_valid    (out_valid),
      .out_legal_id (out_legal_id),
      .out_err      (out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got valid/legal/err=%b, want %b", name, act, req);
      end
   endtask

   // Monitor: every verdict pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_verdict", {out_valid, out_legal_id, out_err}, 3'b000);
         end else begin
            e = exp_q.pop_front();
            check("verdict", {out_valid, out_legal_id, out_err}, {1'b1, e.legal, e.err});
         end
      end else if (out_legal_id || out_err) begin
         check("idle_outputs", {out_valid, out_legal_id, out_err}, 3'b000);
      end
   end

   task automatic expect_verdict(input logic legal, input logic err);
      exp_t e;
      e.legal = legal;
      e.err   = err;
      exp_q.push_back(e);
   endtask

   // Drive len characters; in_mode is inverted after the first one to show it is ignored.
   task automatic send(input logic mode, input int c[11], input int len);
      for (int i = 0; i < len; i++) begin
         in_valid = 1'b1;
         in_mode  = (i == 0) ? mode : ~mode;
         in_id    = 6'(c[i]);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int f[11];
      int g[11];

      #1;
      check("reset_outputs", {out_valid, out_legal_id, out_err}, 3'b000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // Mode 0: letter 10 -> 1, digits 1..8 weighted 8..1 -> 120, last digit weight 1.
      f = '{10, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
      expect_verdict(1'b1, 1'b0); send(1'b0, f, 10); idle(1);
      f = '{10, 1, 2, 3, 4, 5, 6, 7, 8, 8, 0};
      expect_verdict(1'b0, 1'b0); send(1'b0, f, 10); idle(1);
      // Letter 11 -> 0, letter 35 -> 8, letter 19 -> 2.
      f = '{11, 1, 2, 3, 4, 5, 6, 7, 8, 0, 0};
      expect_verdict(1'b1, 1'b0); send(1'b0, f, 10); idle(1);
      f = '{35, 1, 2, 3, 4, 5, 6, 7, 8, 2, 0};
      expect_verdict(1'b1, 1'b0); send(1'b0, f, 10); idle(1);
      f = '{19, 1, 2, 3, 4, 5, 6, 7, 8, 8, 0};
      expect_verdict(1'b1, 1'b0); send(1'b0, f, 10); idle(1);

      // Mode 1 Luhn.
      f = '{1, 2, 3, 4, 5, 6, 7, 8, 2, 0, 0};
      expect_verdict(1'b1, 1'b0); send(1'b1, f, 9); idle(1);
      f = '{1, 2, 3, 4, 5, 6, 7, 8, 3, 0, 0};
      expect_verdict(1'b0, 1'b0); send(1'b1, f, 9); idle(1);
      f = '{7, 9, 9, 2, 7, 3, 9, 8, 2, 0, 0};
      expect_verdict(1'b1, 1'b0); send(1'b1, f, 9); idle(1);
      f = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      expect_verdict(1'b1, 1'b0); send(1'b1, f, 9); idle(1);

      // Out-of-range characters.
      f = '{9, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
      expect_verdict(1'b0, 1'b1); send(1'b0, f, 10); idle(1);
      f = '{36, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
      expect_verdict(1'b0, 1'b1); send(1'b0, f, 10); idle(1);
      f = '{10, 1, 2, 3, 12, 5, 6, 7, 8, 9, 0};
      expect_verdict(1'b0, 1'b1); send(1'b0, f, 10); idle(1);
      f = '{1, 2, 3, 10, 5, 6, 7, 8, 2, 0, 0};
      expect_verdict(1'b0, 1'b1); send(1'b1, f, 9); idle(1);

      // Back-to-back legal frames, mode 0 then mode 1, no idle cycle between them.
      f = '{10, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
      g = '{1, 2, 3, 4, 5, 6, 7, 8, 2, 0, 0};
      expect_verdict(1'b1, 1'b0);
      expect_verdict(1'b1, 1'b0);
      send(1'b0, f, 10);
      send(1'b1, g, 9);
      idle(1);

      // Frame abandoned after 5 characters, then a full legal frame.
      f = '{10, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
      send(1'b0, f, 5);
      idle(1);
      expect_verdict(1'b1, 1'b0); send(1'b0, f, 10); idle(1);

      // Reset while a verdict is being presented: outputs must clear at once.
      send(1'b0, f, 10);
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {out_valid, out_legal_id, out_err}, 3'b000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // Reset mid-frame: that frame yields nothing, the next one starts clean.
      send(1'b1, g, 4);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("reset_midframe_outputs", {out_valid, out_legal_id, out_err}, 3'b000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      expect_verdict(1'b1, 1'b0); send(1'b1, g, 9); idle(1);

      // Bounded drain of outstanding expectations.
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d verdicts outstanding, want 0", exp_q.size());
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
